arbiter_burst: RTL and testbench
================================

# arbiter_burst

Round-robin arbiter that grants ownership of a shared resource for a multi-cycle burst rather than per cycle. An owner holds the grant while its request stays high, up to a fixed burst limit. Priority then rotates to the port after the releasing owner. It sits between the requesting actors and a shared bus or port, alongside the single-cycle `arbiter`, wherever a resource must not be re-arbitrated mid-transfer.

## Interface
- `NUM_PORTS`, 6: number of requesters, ≥ 2.
- `MAX_BURST`, 16: maximum consecutive grant cycles per ownership, ≥ 1.
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `request`  in  `NUM_PORTS`: per-port request; held high for as long as the port wants ownership.
- `lock`  in  1: owner burst extension; present only with `ARBITER_LOCK_EN`.
- `grant`  out  `NUM_PORTS`: registered, one-hot or zero.
- `owner`  out  `clog2(NUM_PORTS)`: registered index of the current or last owner.
- `active`  out  1: registered; equals `|grant`.

## Operation
- FSM with two states.
  - IDLE: `grant` = 0.
  - GRANT: exactly one `grant` bit high.
- Registers:
  - `ptr`: highest-priority port index.
  - `cnt`: grant cycles elapsed; width `clog2(MAX_BURST+1)`.
- IDLE, at the clock edge with `|request`:
  - Winner = first set `request` bit scanning `ptr`, `ptr+1`, … with wrap at `NUM_PORTS-1` → 0.
  - `grant` <= onehot(winner); `owner` <= winner; `cnt` <= 1; state <= GRANT.
- IDLE with no request: hold. `owner` and `ptr` are unchanged.
- GRANT, at the clock edge, release when `!request[owner]` or `cnt == MAX_BURST`. On release:
  - `grant` <= 0; state <= IDLE.
  - `ptr` <= `owner+1`, wrapping `NUM_PORTS-1` → 0.
- GRANT without release: `cnt` <= `cnt+1`; `grant` held.
- Requests from non-owners are ignored in GRANT. No pre-emption.
- Reset (asynchronous, effective immediately, including mid-burst): state IDLE, `grant` = 0, `active` = 0, `owner` = 0, `ptr` = 0, `cnt` = 0.

## Timing
- Request-to-grant latency: 1 cycle. A request high at edge *t* in IDLE gives `grant` high from *t* onward, visible in cycle *t+1*.
- Request drop: `grant` falls the cycle after `request[owner]` is sampled low.
- Held request: `grant` stays high for exactly `MAX_BURST` cycles.
- Dead cycle: at least one cycle with `grant` = 0 between any two ownerships, including re-grant to the same port. Grants to different ports never overlap.
- Burst-limit re-grant: if only the expired owner still requests, it is re-granted after the one dead cycle.
- `MAX_BURST` = 1: grant pattern is 1 cycle on, 1 cycle off.
- Simultaneous requests in IDLE: the winner is decided by `ptr` only.

## Configuration
- `ARBITER_LOCK_EN` defined:
  - `lock` port exists.
  - While in GRANT with `lock` high, the `cnt == MAX_BURST` release condition is suppressed, and `cnt` saturates at `MAX_BURST`.
  - Dropping `request[owner]` still releases.
  - If `lock` falls with `cnt == MAX_BURST`, release occurs at that edge.
- `ARBITER_LOCK_EN` undefined: no `lock` port; the burst limit is always enforced.

## Structure
- Shared package `arbiter_pkg`:
  - State encoding (`ARB_IDLE`, `ARB_GRANT`).
  - `clog2` function.
  - Onehot-to-index function.
- Sub-module `arbiter_rr_pick`: combinational; inputs `request` and `ptr`, output one-hot winner. Implemented as a rotated priority encoder.
- FSM, `cnt`, `ptr` and output registers live in the top module.

## Test plan
Bench uses `NUM_PORTS` = 4 and `MAX_BURST` = 4.
- Single requester: `request` = 0b0100 held 10 cycles → `grant` = 0b0100 for 4 cycles, 0 for 1 cycle, 0b0100 for 4 cycles; `owner` = 2.
- Rotation: `request` = 0b1111 held → owners 0, 1, 2, 3, 0; each burst is 4 cycles with 1 dead cycle; `active` is low only in the dead cycles.
- Early release: port 1 owns, `request[1]` drops after 2 grant cycles, port 3 is pending → `grant` = 0 for 1 cycle, then 0b1000; `ptr` = 2 after release.
- Wrap: port 3 owns and releases, `request` = 0b1001 → next grant goes to port 0.
- Reset mid-burst: assert `rst` in the 3rd grant cycle → `grant`, `active` and `owner` go to 0 without waiting for a clock edge; after deassertion, `request` = 0b0110 → port 1 is granted.
- With `ARBITER_LOCK_EN`: `lock` = 1 and `request[0]` held 8 cycles → `grant` = 0b0001 for 8 cycles; dropping `lock` with `cnt` saturated → release at that edge.

Source files
------------

// File: rtl/arbiter_pkg.sv
// ============================================================
// arbiter_pkg : shared state encoding and helper functions
// Rev 1.0
// ============================================================
`default_nettype none

package arbiter_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int oh2idx(input logic [31:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/arbiter_rr_pick.sv
// ============================================================
// arbiter_rr_pick : rotated priority encoder, one-hot winner from ptr upward
// Rev 1.0
// ============================================================
`default_nettype none

module arbiter_rr_pick
  import arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 6
) (
  input  logic [NUM_PORTS-1:0]        request,
  input  logic [clog2(NUM_PORTS)-1:0] ptr,
  output logic [NUM_PORTS-1:0]        pick
);

  localparam int OW = clog2(NUM_PORTS);

  logic [NUM_PORTS-1:0] w_rot;
  logic [NUM_PORTS-1:0] w_first;

  // Rotate so ptr lands at bit 0, isolate lowest set bit, rotate back.
  always_comb begin
    logic [OW-1:0] idx;
    w_rot = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx      = OW'((int'(ptr) + k) % NUM_PORTS);
      w_rot[k] = request[idx];
    end
  end

  assign w_first = w_rot & (~w_rot + NUM_PORTS'(1));

  always_comb begin
    logic [OW-1:0] idx;
    pick = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = OW'((int'(ptr) + k) % NUM_PORTS);
      if (w_first[k]) pick[idx] = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/arbiter_burst.sv
// ============================================================
// arbiter_burst : round-robin arbiter granting multi-cycle bursts
// Optional burst extension via `lock` when ARBITER_LOCK_EN is defined.  Rev 1.0
// ============================================================
`default_nettype none

module arbiter_burst
  import arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 6,
  parameter int MAX_BURST = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        request,
`ifdef ARBITER_LOCK_EN
  input  logic                        lock,
`endif
  output logic [NUM_PORTS-1:0]        grant,
  output logic [clog2(NUM_PORTS)-1:0] owner,
  output logic                        active
);

  localparam int OW = clog2(NUM_PORTS);
  localparam int CW = clog2(MAX_BURST + 1);

  arb_state_t           r_state, w_state_nxt;
  logic [NUM_PORTS-1:0] r_grant, w_grant_nxt, w_pick;
  logic [OW-1:0]        r_owner, w_owner_nxt, r_ptr, w_ptr_nxt, w_pick_idx;
  logic [CW-1:0]        r_cnt, w_cnt_nxt;
  logic                 r_active;
  logic                 w_at_limit, w_limit_rel, w_release;

  arbiter_rr_pick #(.NUM_PORTS(NUM_PORTS)) u_pick (
    .request (request),
    .ptr     (r_ptr),
    .pick    (w_pick)
  );

  assign w_pick_idx = OW'(oh2idx(32'(w_pick)));
  assign w_at_limit = (r_cnt == CW'(MAX_BURST));

`ifdef ARBITER_LOCK_EN
  assign w_limit_rel = w_at_limit && !lock;
`else
  assign w_limit_rel = w_at_limit;
`endif

  assign w_release = !request[r_owner] || w_limit_rel;

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ARB_IDLE: begin
        if (|request) begin
          w_state_nxt = ARB_GRANT;
          w_grant_nxt = w_pick;
          w_owner_nxt = w_pick_idx;
          w_cnt_nxt   = CW'(1);
        end
      end
      ARB_GRANT: begin
        if (w_release) begin
          w_state_nxt = ARB_IDLE;
          w_grant_nxt = '0;
          w_ptr_nxt   = (r_owner == OW'(NUM_PORTS - 1)) ? '0 : r_owner + OW'(1);
        end else if (!w_at_limit) begin
          // Saturation only matters while a lock is holding the burst open.
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = ARB_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ARB_IDLE;
      r_grant  <= '0;
      r_owner  <= '0;
      r_ptr    <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_owner  <= w_owner_nxt;
      r_ptr    <= w_ptr_nxt;
      r_cnt    <= w_cnt_nxt;
      r_active <= |w_grant_nxt;
    end
  end

  assign grant  = r_grant;
  assign owner  = r_owner;
  assign active = r_active;

endmodule

`default_nettype wire

// File: tb/tb_arbiter_burst.sv
// ============================================================
// tb_arbiter_burst : directed and randomized checks against a behavioural model
// Rev 1.0
// ============================================================
`default_nettype none

module tb_arbiter_burst;

  localparam int N  = 4;
  localparam int MB = 4;
`ifdef ARBITER_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         lock;
  logic [N-1:0] request;
  logic [N-1:0] grant;
  logic [1:0]   owner;
  logic         active;

  int n_total = 0;
  int n_bad   = 0;

  bit m_busy;
  int m_owner, m_ptr, m_cnt;

  always #5 clk = ~clk;

  arbiter_burst #(.NUM_PORTS(N), .MAX_BURST(MB)) dut (
    .clk     (clk),
    .rst     (rst),
    .request (request),
`ifdef ARBITER_LOCK_EN
    .lock    (lock),
`endif
    .grant   (grant),
    .owner   (owner),
    .active  (active)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_cnt = 0;
  endtask

  // Next ownership from the rules: first requester at/after ptr, burst cap, lock extension.
  task automatic model_step(input logic [N-1:0] req, input logic lk);
    bit lim;
    if (!m_busy) begin
      if (req != 0) begin
        for (int k = 0; k < N; k++) begin
          if (req[(m_ptr + k) % N]) begin
            m_owner = (m_ptr + k) % N;
            break;
          end
        end
        m_busy = 1'b1;
        m_cnt  = 1;
      end
    end else begin
      lim = (m_cnt >= MB) && !(LOCK_EN && lk);
      if (!req[m_owner] || lim) begin
        m_busy = 1'b0;
        m_ptr  = (m_owner + 1) % N;
      end else if (m_cnt < MB) begin
        m_cnt++;
      end
    end
  endtask

  task automatic check_outs(input string tag);
    logic [31:0] eg;
    eg = m_busy ? (32'd1 << m_owner) : 32'd0;
    chk({tag, ".grant"},  32'(grant),  eg);
    chk({tag, ".owner"},  32'(owner),  32'(m_owner));
    chk({tag, ".active"}, 32'(active), 32'(m_busy));
  endtask

  task automatic step(input logic [N-1:0] req, input string tag);
    request = req;
    model_step(req, lock);
    @(posedge clk);
    @(negedge clk);
    check_outs(tag);
  endtask

  task automatic do_reset();
    request = '0;
    rst     = 1'b1;
    model_reset();
    @(negedge clk);
    check_outs("reset");
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] single_exp [10];
    logic [31:0] e;
    logic [N-1:0] req;
    int len;

    single_exp = '{4, 4, 4, 4, 0, 4, 4, 4, 4, 0};
    rst = 1'b1; request = '0; lock = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outs("reset0");
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      step(4'b0100, "single");
      chk("single_seq", 32'(grant), single_exp[i]);
    end

    do_reset();
    for (int i = 0; i < 25; i++) begin
      step(4'b1111, "rot");
      e = ((i % 5) == 4) ? 32'd0 : (32'd1 << ((i / 5) % 4));
      chk("rot_seq", 32'(grant), e);
    end

    do_reset();
    step(4'b1010, "early"); chk("early_g1", 32'(grant), 32'd2);
    step(4'b1010, "early"); chk("early_g2", 32'(grant), 32'd2);
    step(4'b1000, "early"); chk("early_dead", 32'(grant), 32'd0);
    step(4'b1000, "early"); chk("early_p3", 32'(grant), 32'd8);
    for (int i = 0; i < 4; i++) step(4'b1001, "wrap");
    step(4'b1001, "wrap");
    chk("wrap_p0", 32'(grant), 32'd1);

    do_reset();
    for (int i = 0; i < 3; i++) step(4'b0100, "midburst");
    #2 rst = 1'b1;
    model_reset();
    #1;
    check_outs("async_rst");
    chk("async_rst_grant", 32'(grant), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step(4'b0110, "post_rst");
    chk("post_rst_p1", 32'(grant), 32'd2);

`ifdef ARBITER_LOCK_EN
    do_reset();
    lock = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(4'b0001, "lock");
      chk("lock_held", 32'(grant), 32'd1);
    end
    lock = 1'b0;
    step(4'b0001, "unlock");
    chk("unlock_rel", 32'(grant), 32'd0);
`endif

    do_reset();
    for (int p = 0; p < 300; p++) begin
      req = N'($urandom_range(0, 15));
      len = $urandom_range(1, 8);
      if (LOCK_EN) lock = ($urandom_range(0, 2) == 0);
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 3) == 0) req = N'($urandom);
        step(req, "rand");
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
